memory_port_arbiter: RTL and testbench
======================================

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 2, meaning the number of hart-side requesters; it SHALL be fixed at 2 for this revision.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-004 Ports SHALL be:
  clock  in  1  single clock; all state changes on the rising edge
  clear  in  1  reset, asynchronous, active-high
  req_valid[p]  in  1 each  request from port p (p=0 fetch, p=1 load/store)
  req_address[p]  in  ADDR_W each  request address
  req_write[p]  in  1 each  1=write, 0=read
  req_write_data[p]  in  DATA_W each  write data
  req_ready[p]  out  1 each  request accepted this cycle
  resp_valid[p]  out  1 each  response for port p
  resp_error[p]  out  1 each  response error
  resp_read_data[p]  out  DATA_W each  read data
  resp_ready[p]  in  1 each  port p accepts response
  mem_valid  out  1  downstream request valid
  mem_address  out  ADDR_W  downstream address
  mem_write  out  1  downstream write
  mem_write_data  out  DATA_W  downstream write data
  mem_ready  in  1  downstream accepts request
  mem_resp_valid  in  1  downstream response valid
  mem_resp_error  in  1  downstream response error
  mem_resp_read_data  in  DATA_W  downstream read data
  mem_resp_ready  out  1  arbiter accepts response

Function
REQ-005 The FSM SHALL have states IDLE and WAIT_RESP, with at most one outstanding transaction.
REQ-006 In IDLE, the grant SHALL go to the requesting port with priority from last_grant: the port after last_grant wins; with a single requester, that requester wins.
REQ-007 In IDLE with a grant g: mem_valid=1; mem_address, mem_write and mem_write_data SHALL equal port g's fields; req_ready[g]=mem_ready; all other req_ready=0.
REQ-008 A request SHALL transfer when mem_valid & mem_ready; on that edge the FSM SHALL go to WAIT_RESP, owner SHALL become g, and last_grant SHALL become g.
REQ-009 In WAIT_RESP: mem_valid=0; all req_ready=0; resp_valid[owner]=mem_resp_valid; resp_error[owner]=mem_resp_error; resp_read_data[owner]=mem_resp_read_data; mem_resp_ready=resp_ready[owner].
REQ-010 The response SHALL complete when mem_resp_valid & mem_resp_ready, and the FSM SHALL return to IDLE on that edge; a new grant SHALL be possible on the next cycle, giving a minimum of 2 cycles per transaction.
REQ-011 For non-owner ports, resp_valid and resp_error SHALL be 0 at all times.
REQ-012 resp_read_data SHALL be broadcast to all ports; only resp_valid qualifies it.
REQ-013 In IDLE, mem_resp_ready SHALL be 1 and any mem_resp_valid SHALL be dropped; this is a protocol violation by memory, and the FSM SHALL NOT change state.
REQ-014 In IDLE with no req_valid: mem_valid=0; mem_address, mem_write and mem_write_data SHALL be 0.
REQ-015 Request outputs SHALL be purely combinational from state and inputs, adding 0 cycles of latency; owner and last_grant SHALL be registered.
REQ-016 A req_valid deasserted before the transfer SHALL cause no state change.

Reset
REQ-017 While clear=1: state=IDLE, owner=0, last_grant=NUM_PORTS-1 (port 0 wins the first contested grant); all outputs SHALL take their IDLE/no-request values.
REQ-018 Assertion of clear during WAIT_RESP SHALL abandon the outstanding transaction; a late memory response SHALL then be handled per REQ-013.

Configuration
REQ-019 With macro MEMORY_PORT_ARBITER_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-006; without it, arbitration SHALL be fixed priority with port 0 always winning, and last_grant SHALL still update but SHALL be ignored.

Structure
REQ-020 A shared package SHALL hold the state enum (IDLE, WAIT_RESP), the port index constants FETCH_PORT=0 and LSU_PORT=1, and the request and response struct typedefs.
REQ-021 Grant selection SHALL be one sub-module, rr_grant (req vector, last_grant -> one-hot grant); everything else SHALL be flat.

Verification
REQ-022 Single read: port 0 issues addr 0x100 with mem_ready=1 -> mem_valid the same cycle; next cycle, a response of 0xDEADBEEF routes to resp_*[0] only.
REQ-023 Contention, round-robin: both ports valid continuously, memory responds after 1 cycle -> grants alternate 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-024 Backpressure: mem_ready=0 for 3 cycles -> req_ready=0, mem outputs stable, no grant change while the requester holds valid; accept on cycle 4.
REQ-025 Error plus stall: port 1 writes 0x55 to 0x200, response has error=1 while resp_ready[1]=0 for 2 cycles -> mem_resp_ready=0, the FSM stays in WAIT_RESP, and the response then completes with resp_error[1]=1.
REQ-026 Reset in WAIT_RESP: clear asserted mid-transaction -> all outputs idle; a stray mem_resp_valid afterward -> no resp_valid on any port.

Source files
------------

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for memory_port_arbiter: FSM state, port indices and request/response records.
package memory_port_arbiter_pkg;

  localparam int unsigned FETCH_PORT = 0;
  localparam int unsigned LSU_PORT   = 1;

  localparam int unsigned PKG_ADDR_W = 32;
  localparam int unsigned PKG_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [PKG_ADDR_W-1:0] addr;
    logic                  write;
    logic [PKG_DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                  valid;
    logic                  error;
    logic [PKG_DATA_W-1:0] rdata;
  } resp_t;

endpackage

// File: rtl/memory_port_arbiter_rr_grant.sv
// One-hot grant selection for memory_port_arbiter.
// MEMORY_PORT_ARBITER_ROUND_ROBIN_EN selects round-robin from last_grant; otherwise fixed priority, port 0 highest.
module rr_grant #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_W    = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_grant,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef MEMORY_PORT_ARBITER_ROUND_ROBIN_EN
  // Search starts at the port after last_grant and wraps, so the previous winner is checked last.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      if (!found && req[(32'(last_grant) + i) % NUM_PORTS]) begin
        grant[(32'(last_grant) + i) % NUM_PORTS] = 1'b1;
        found = 1'b1;
      end
    end
  end
`else
  logic last_grant_unused;
  assign last_grant_unused = ^last_grant;

  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates hart-side fetch/LSU ports onto one memory port, one outstanding transaction at a time.
// Define MEMORY_PORT_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0).
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic [NUM_PORTS-1:0]              req_valid,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  req_address,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  req_write_data,
  output logic [NUM_PORTS-1:0]              req_ready,
  output logic [NUM_PORTS-1:0]              resp_valid,
  output logic [NUM_PORTS-1:0]              resp_error,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  resp_read_data,
  input  logic [NUM_PORTS-1:0]              resp_ready,
  output logic                              mem_valid,
  output logic [ADDR_W-1:0]                 mem_address,
  output logic                              mem_write,
  output logic [DATA_W-1:0]                 mem_write_data,
  input  logic                              mem_ready,
  input  logic                              mem_resp_valid,
  input  logic                              mem_resp_error,
  input  logic [DATA_W-1:0]                 mem_resp_read_data,
  output logic                              mem_resp_ready
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e              state_q, state_d;
  logic [PORT_W-1:0]   owner_q, owner_d;
  logic [PORT_W-1:0]   last_grant_q, last_grant_d;

  logic [NUM_PORTS-1:0] req_act;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    gnt_idx;

  // Requests are masked while clear is held so every output shows its idle value.
  assign req_act = clear ? '0 : req_valid;

  rr_grant #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_rr_grant (
    .req        (req_act),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) gnt_idx = PORT_W'(i);
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    mem_valid      = 1'b0;
    mem_address    = '0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    req_ready      = '0;
    resp_valid     = '0;
    resp_error     = '0;
    mem_resp_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      resp_read_data[i] = mem_resp_read_data;
    end

    unique case (state_q)
      IDLE: begin
        // A response arriving here has no owner; it is accepted and dropped.
        if (|grant) begin
          mem_valid          = 1'b1;
          mem_address        = req_address[gnt_idx];
          mem_write          = req_write[gnt_idx];
          mem_write_data     = req_write_data[gnt_idx];
          req_ready[gnt_idx] = mem_ready;
          if (mem_ready) begin
            state_d      = WAIT_RESP;
            owner_d      = gnt_idx;
            last_grant_d = gnt_idx;
          end
        end
      end
      WAIT_RESP: begin
        resp_valid[owner_q] = mem_resp_valid;
        resp_error[owner_q] = mem_resp_error;
        mem_resp_ready      = resp_ready[owner_q];
        if (mem_resp_valid && resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= IDLE;
      owner_q      <= PORT_W'(FETCH_PORT);
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter: stimulus pushes expected transfers/responses, a monitor pops and compares.
module tb_memory_port_arbiter;
  import memory_port_arbiter_pkg::*;

  typedef struct {
    int unsigned port;
    req_t        req;
  } exp_req_t;

  typedef struct {
    int unsigned port;
    resp_t       resp;
  } exp_resp_t;

  logic              clock = 1'b0;
  logic              clear;
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_address;
  logic [1:0]        req_write;
  logic [1:0][31:0]  req_write_data;
  logic [1:0]        req_ready;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_error;
  logic [1:0][31:0]  resp_read_data;
  logic [1:0]        resp_ready;
  logic              mem_valid;
  logic [31:0]       mem_address;
  logic              mem_write;
  logic [31:0]       mem_write_data;
  logic              mem_ready;
  logic              mem_resp_valid;
  logic              mem_resp_error;
  logic [31:0]       mem_resp_read_data;
  logic              mem_resp_ready;

  int n_tests = 0;
  int n_fail  = 0;

  exp_req_t  exp_req_q[$];
  exp_resp_t exp_resp_q[$];

  always #5 clock = ~clock;

  memory_port_arbiter #(
    .NUM_PORTS (2),
    .ADDR_W    (32),
    .DATA_W    (32)
  ) dut (
    .clock              (clock),
    .clear              (clear),
    .req_valid          (req_valid),
    .req_address        (req_address),
    .req_write          (req_write),
    .req_write_data     (req_write_data),
    .req_ready          (req_ready),
    .resp_valid         (resp_valid),
    .resp_error         (resp_error),
    .resp_read_data     (resp_read_data),
    .resp_ready         (resp_ready),
    .mem_valid          (mem_valid),
    .mem_address        (mem_address),
    .mem_write          (mem_write),
    .mem_write_data     (mem_write_data),
    .mem_ready          (mem_ready),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_error     (mem_resp_error),
    .mem_resp_read_data (mem_resp_read_data),
    .mem_resp_ready     (mem_resp_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_req(input int unsigned port, input logic [31:0] addr,
                          input logic wr, input logic [31:0] wdata);
    exp_req_t e;
    e.port      = port;
    e.req.valid = 1'b1;
    e.req.addr  = addr;
    e.req.write = wr;
    e.req.wdata = wdata;
    exp_req_q.push_back(e);
  endtask

  task automatic push_resp(input int unsigned port, input logic [31:0] rdata, input logic err);
    exp_resp_t e;
    e.port       = port;
    e.resp.valid = 1'b1;
    e.resp.error = err;
    e.resp.rdata = rdata;
    exp_resp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_address"}, mem_address, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_wdata"}, mem_write_data, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_error"}, resp_error, 0);
    chk({tag, "_mem_resp_ready"}, mem_resp_ready, 1);
  endtask

  task automatic do_reset();
    clear              = 1'b1;
    req_valid          = '0;
    req_address        = '0;
    req_write          = '0;
    req_write_data     = '0;
    resp_ready         = '0;
    mem_ready          = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_error     = 1'b0;
    mem_resp_read_data = '0;
    tick();
    tick();
    clear = 1'b0;
  endtask

  // Monitor: compares every handshake the DUT presents against the queued expectations.
  exp_req_t  mr;
  exp_resp_t ms;
  always @(negedge clock) begin
    if (!clear) begin
      if (mem_valid && mem_ready) begin
        if (exp_req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: addr 0x%0h req_ready %b, none expected", mem_address, req_ready);
        end else begin
          mr = exp_req_q.pop_front();
          chk("req_grant", req_ready, 64'(2'b01 << mr.port));
          chk("req_addr", mem_address, mr.req.addr);
          chk("req_write", mem_write, mr.req.write);
          chk("req_wdata", mem_write_data, mr.req.wdata);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (resp_valid[p] && resp_ready[p]) begin
          if (exp_resp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: port %0d data 0x%0h, none expected", p, resp_read_data[p]);
          end else begin
            ms = exp_resp_q.pop_front();
            chk("resp_port", p, ms.port);
            chk("resp_data", resp_read_data[p], ms.resp.rdata);
            chk("resp_error", resp_error[p], ms.resp.error);
          end
        end
      end
    end
  end

  initial begin
    // Reset values, including with requests asserted during clear.
    do_reset();
    clear = 1'b1;
    req_valid = 2'b11;
    req_address[0] = 32'h0000_0ABC;
    #2;
    check_idle_outputs("reset");
    tick();
    do_reset();

    // Single read from port 0.
    req_valid = 2'b01; req_address[0] = 32'h100; req_write[0] = 1'b0;
    req_write_data[0] = 32'h0; mem_ready = 1'b1;
    push_req(0, 32'h100, 1'b0, 32'h0);
    tick();
    req_valid = 2'b00; mem_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_error = 1'b0; mem_resp_read_data = 32'hDEADBEEF;
    resp_ready = 2'b11;
    push_resp(0, 32'hDEADBEEF, 1'b0);
    #2;
    chk("single_resp_valid", resp_valid, 2'b01);
    chk("single_broadcast1", resp_read_data[1], 32'hDEADBEEF);
    tick();
    mem_resp_valid = 1'b0;

    // Contention with both ports continuously valid.
    do_reset();
    resp_ready = 2'b11;
    req_valid = 2'b11;
    req_address[0] = 32'h1000; req_write[0] = 1'b0; req_write_data[0] = 32'h77;
    req_address[1] = 32'h2000; req_write[1] = 1'b1; req_write_data[1] = 32'h1111;
    for (int k = 0; k < 4; k++) begin
      int unsigned g;
`ifdef MEMORY_PORT_ARBITER_ROUND_ROBIN_EN
      g = k % 2;
`else
      g = 0;
`endif
      mem_ready = 1'b1; mem_resp_valid = 1'b0;
      if (g == 0) push_req(0, 32'h1000, 1'b0, 32'h77);
      else        push_req(1, 32'h2000, 1'b1, 32'h1111);
      tick();
      mem_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_read_data = 32'hC0DE0000 + k;
      push_resp(g, 32'hC0DE0000 + k, 1'b0);
      tick();
    end
    req_valid = 2'b00; mem_resp_valid = 1'b0;

    // Backpressure: memory stalls three cycles, accepts on the fourth.
    req_valid = 2'b10; req_address[1] = 32'h300; req_write[1] = 1'b0; req_write_data[1] = 32'h9;
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_mem_valid", mem_valid, 1);
      chk("bp_mem_addr", mem_address, 32'h300);
      chk("bp_mem_wdata", mem_write_data, 32'h9);
      tick();
    end
    mem_ready = 1'b1;
    push_req(1, 32'h300, 1'b0, 32'h9);
    tick();
    req_valid = 2'b00; mem_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_read_data = 32'h12345678;
    push_resp(1, 32'h12345678, 1'b0);
    tick();
    mem_resp_valid = 1'b0;

    // Error response held while port 1 stalls.
    req_valid = 2'b10; req_address[1] = 32'h200; req_write[1] = 1'b1; req_write_data[1] = 32'h55;
    mem_ready = 1'b1;
    push_req(1, 32'h200, 1'b1, 32'h55);
    tick();
    req_valid = 2'b01; req_address[0] = 32'h500; mem_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_error = 1'b1; mem_resp_read_data = 32'hBAD;
    resp_ready = 2'b01;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("stall_mem_resp_ready", mem_resp_ready, 0);
      chk("stall_resp_valid", resp_valid, 2'b10);
      chk("stall_resp_error", resp_error, 2'b10);
      chk("stall_mem_valid", mem_valid, 0);
      chk("stall_req_ready", req_ready, 2'b00);
      tick();
    end
    req_valid = 2'b00;
    resp_ready = 2'b11;
    push_resp(1, 32'hBAD, 1'b1);
    tick();
    mem_resp_valid = 1'b0; mem_resp_error = 1'b0;

    // Clear during WAIT_RESP, then a stray late response.
    req_valid = 2'b01; req_address[0] = 32'h400; req_write[0] = 1'b0; req_write_data[0] = 32'h0;
    mem_ready = 1'b1;
    push_req(0, 32'h400, 1'b0, 32'h0);
    tick();
    req_valid = 2'b00; mem_ready = 1'b0;
    clear = 1'b1;
    #2;
    check_idle_outputs("clear_wait");
    tick();
    clear = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_read_data = 32'hFEED; resp_ready = 2'b11;
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("stray_resp_valid", resp_valid, 2'b00);
      chk("stray_mem_resp_ready", mem_resp_ready, 1);
      tick();
    end
    mem_resp_valid = 1'b0;

    tick();
    chk("req_queue_drained", exp_req_q.size(), 0);
    chk("resp_queue_drained", exp_resp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
